frame_sync_regs: RTL and testbench
==================================

// Module: frame_sync_regs
// PURPOSE
//  Avalon-MM register bank placed upstream of the VGA renderer. Software writes the
//  background colour and the ball bounding box into shadow registers. The shadow
//  values reach the renderer's live outputs only at the start of vertical blank, so a
//  frame is never drawn with a mix of old and new values. Geometry is scaled x5 here.
// PARAMETERS
//  AUTO_COMMIT  0      1: commit any dirty shadow every frame; 0: commit only on request
//  VBLANK_LINE  480    vcount value at which the commit point occurs (with hcount==0)
//  SCALE        5      multiplier that converts 8-bit geometry writes to pixel units
// PORTS
//  clk           in   1   system clock (50 MHz); single clock domain
//  reset         in   1   synchronous, active-high
//  chipselect    in   1   Avalon chip select
//  write         in   1   Avalon write strobe
//  read          in   1   Avalon read strobe
//  address       in   3   register index 0..7
//  writedata     in   8   write data
//  readdata      out  8   read data, valid 1 cycle after read&chipselect
//  hcount        in   11  pixel counter from vga_counters
//  vcount        in   10  line counter from vga_counters
//  bg_r,bg_g,bg_b out 8   live background colour
//  h_start,h_end out  11  live horizontal box bounds, in pixel units
//  v_start,v_end out  11  live vertical box bounds, in pixel units
//  commit_pending out 1   a commit is armed and has not yet executed
//  frame_count   out  8   number of commit points seen; wraps 255->0
// BEHAVIOUR
//  - Reset: shadow and live bg = {00,00,80}; all shadow and live bounds = 0; dirty = 0;
//    FSM = IDLE; frame_count = 0; readdata = 0; commit_pending = 0.
//  - Writes (chipselect&write), addr 0-6: shadow[addr] <= writedata; dirty <= 1.
//    Addresses 3-6 are stored as writedata*SCALE, 11-bit unsigned (255*5 = 1275 fits).
//  - Addr 7 write: bit0 = 1 requests a commit; other bits are ignored.
//  - Reads: addr 0-6 return the shadow value; for 3-6 this is the stored value divided
//    by SCALE, i.e. the original byte. Addr 7 returns {commit_pending, dirty, 6'b0}.
//    readdata is registered and has a latency of 1 cycle. When there is no read, readdata
//    holds its last value.
//  - Commit point (cp): single-cycle pulse, true when hcount==0 && vcount==VBLANK_LINE.
//    frame_count increments at every cp, whatever the FSM state.
//  - FSM:
//    IDLE   -> ARMED  on a commit request, or when AUTO_COMMIT && dirty.
//    ARMED  -> COMMIT on cp. commit_pending = 1 while in ARMED.
//    COMMIT -> IDLE   after 1 cycle. In that cycle live <= shadow and dirty <= 0.
//  - Ordering on commit: if shadow h_start > h_end, the live h bounds are written swapped.
//    The same applies to v. Live outputs then always satisfy start <= end.
//  - Live outputs change only in the COMMIT cycle, which is 1 clk after cp. They are
//    therefore stable over the whole active region.
//  - Simultaneous events:
//    - A shadow write in the COMMIT cycle: the live value takes the pre-write shadow;
//      the new write sets dirty, so it goes out at the next commit.
//    - A request while ARMED: no effect.
//    - A request in the COMMIT cycle: FSM goes back to ARMED (not IDLE).
//    - A request and cp in the same IDLE cycle: FSM goes to ARMED; the commit happens at
//      the next frame's cp.
//  - Reset mid-operation: any armed commit is discarded and all values return to reset.
//  - Only commit_pending and the live outputs cross to the renderer. No combinational
//    path from Avalon inputs to live outputs.
// TESTING
//  - Reset, then read addr 2 -> readdata = 0x80 one cycle later. Live bg = {00,00,80}.
//    Live bounds = 0.
//  - Write addr3=10, addr4=20, addr7=1 at vcount=100 -> live stays 0 until cp. At
//    (vcount 480, hcount 0) + 1 clk: h_start = 50, h_end = 100. commit_pending falls.
//  - Write addr5=40, addr6=8, then request -> after the commit: v_start = 40, v_end = 200
//    (swapped). A read of addr5 still returns 40.
//  - AUTO_COMMIT=1: write addr0=FF with no request -> bg_r = FF after the next cp.
//    Addr7 read then returns 0x00.
//  - Write addr1=33 in the COMMIT cycle -> bg_g keeps its old value. Addr7 read = 0x40
//    (dirty set). bg_g = 33 after the following cp.
//  - Request, then reset asserted before cp -> commit_pending = 0. Live values are the
//    reset values. No commit at cp. frame_count counts from 0.

Source files
------------

// File: rtl/frame_sync_regs.sv
// Avalon-MM shadow register bank for the VGA renderer. Shadow values are copied to the
// live outputs once per frame, one clock after the vertical-blank commit point.
module frame_sync_regs #(
  parameter int AUTO_COMMIT = 0,
  parameter int VBLANK_LINE = 480,
  parameter int SCALE       = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [2:0]  address,
  input  logic [7:0]  writedata,
  output logic [7:0]  readdata,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  output logic [7:0]  bg_r,
  output logic [7:0]  bg_g,
  output logic [7:0]  bg_b,
  output logic [10:0] h_start,
  output logic [10:0] h_end,
  output logic [10:0] v_start,
  output logic [10:0] v_end,
  output logic        commit_pending,
  output logic [7:0]  frame_count,
  output logic [1:0]  state_dbg
);

  // Avalon slave: writes complete in the cycle chipselect&write is high; reads
  // complete when chipselect&read is high and readdata is valid one cycle later.
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, COMMIT = 2'd2} state_t;

  state_t      state, state_next;
  logic [7:0]  sh_r, sh_g, sh_b;
  logic [10:0] sh_hs, sh_he, sh_vs, sh_ve;
  logic        dirty;
  logic        wr_en, commit_req, cp;
  logic [7:0]  rd_mux;

  assign wr_en      = chipselect & write;
  assign commit_req = wr_en && (address == 3'd7) && writedata[0];
  assign cp         = (hcount == 11'd0) && (vcount == 10'(VBLANK_LINE));

  function automatic logic [10:0] scale_up(input logic [7:0] b);
    return 11'(b) * 11'(SCALE);
  endfunction

  function automatic logic [7:0] scale_down(input logic [10:0] v);
    return 8'(v / 11'(SCALE));
  endfunction

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (commit_req || ((AUTO_COMMIT != 0) && dirty)) state_next = ARMED;
      ARMED:   if (cp) state_next = COMMIT;
      COMMIT:  state_next = commit_req ? ARMED : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  assign commit_pending = (state == ARMED);
  assign state_dbg      = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_r  <= 8'h00;
      sh_g  <= 8'h00;
      sh_b  <= 8'h80;
      sh_hs <= '0;
      sh_he <= '0;
      sh_vs <= '0;
      sh_ve <= '0;
    end else if (wr_en) begin
      case (address)
        3'd0:    sh_r  <= writedata;
        3'd1:    sh_g  <= writedata;
        3'd2:    sh_b  <= writedata;
        3'd3:    sh_hs <= scale_up(writedata);
        3'd4:    sh_he <= scale_up(writedata);
        3'd5:    sh_vs <= scale_up(writedata);
        3'd6:    sh_ve <= scale_up(writedata);
        default: ;
      endcase
    end
  end

  // A write landing in the COMMIT cycle must survive, so it outranks the clear.
  always_ff @(posedge clk) begin
    if (reset)                           dirty <= 1'b0;
    else if (wr_en && address != 3'd7)   dirty <= 1'b1;
    else if (state == COMMIT)            dirty <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bg_r    <= 8'h00;
      bg_g    <= 8'h00;
      bg_b    <= 8'h80;
      h_start <= '0;
      h_end   <= '0;
      v_start <= '0;
      v_end   <= '0;
    end else if (state == COMMIT) begin
      bg_r    <= sh_r;
      bg_g    <= sh_g;
      bg_b    <= sh_b;
      h_start <= (sh_hs > sh_he) ? sh_he : sh_hs;
      h_end   <= (sh_hs > sh_he) ? sh_hs : sh_he;
      v_start <= (sh_vs > sh_ve) ? sh_ve : sh_vs;
      v_end   <= (sh_vs > sh_ve) ? sh_vs : sh_ve;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)   frame_count <= 8'd0;
    else if (cp) frame_count <= frame_count + 8'd1;
  end

  always_comb begin
    rd_mux = 8'h00;
    case (address)
      3'd0: rd_mux = sh_r;
      3'd1: rd_mux = sh_g;
      3'd2: rd_mux = sh_b;
      3'd3: rd_mux = scale_down(sh_hs);
      3'd4: rd_mux = scale_down(sh_he);
      3'd5: rd_mux = scale_down(sh_vs);
      3'd6: rd_mux = scale_down(sh_ve);
      3'd7: rd_mux = {commit_pending, dirty, 6'b0};
      default: rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)                   readdata <= 8'h00;
    else if (chipselect && read) readdata <= rd_mux;
  end

endmodule

// File: tb/tb_frame_sync_regs.sv
// Directed bench for frame_sync_regs: one instance on request-only commits, one with
// AUTO_COMMIT=1. Read results go through an expected queue.
module tb_frame_sync_regs;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs0, cs1, write, read;
  logic [2:0]  address;
  logic [7:0]  writedata;
  logic [10:0] hcount;
  logic [9:0]  vcount;

  logic [7:0]  rd0, bg_r0, bg_g0, bg_b0, fc0;
  logic [10:0] hs0, he0, vs0, ve0;
  logic        cp0;
  logic [1:0]  st0;
  logic [7:0]  rd1, bg_r1, bg_g1, bg_b1, fc1;
  logic [10:0] hs1, he1, vs1, ve1;
  logic        cp1;
  logic [1:0]  st1;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  exp_fc   = 8'd0;
  logic [7:0]  exp_q[$];

  always #10 clk = ~clk;

  frame_sync_regs #(.AUTO_COMMIT(0)) dut0 (
    .clk(clk), .reset(reset), .chipselect(cs0), .write(write), .read(read),
    .address(address), .writedata(writedata), .readdata(rd0),
    .hcount(hcount), .vcount(vcount),
    .bg_r(bg_r0), .bg_g(bg_g0), .bg_b(bg_b0),
    .h_start(hs0), .h_end(he0), .v_start(vs0), .v_end(ve0),
    .commit_pending(cp0), .frame_count(fc0), .state_dbg(st0)
  );

  frame_sync_regs #(.AUTO_COMMIT(1)) dut1 (
    .clk(clk), .reset(reset), .chipselect(cs1), .write(write), .read(read),
    .address(address), .writedata(writedata), .readdata(rd1),
    .hcount(hcount), .vcount(vcount),
    .bg_r(bg_r1), .bg_g(bg_g1), .bg_b(bg_b1),
    .h_start(hs1), .h_end(he1), .v_start(vs1), .v_end(ve1),
    .commit_pending(cp1), .frame_count(fc1), .state_dbg(st1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int sel, input logic [2:0] a, input logic [7:0] d);
    cs0 = (sel == 0); cs1 = (sel == 1);
    write = 1'b1; address = a; writedata = d;
    tick();
    cs0 = 1'b0; cs1 = 1'b0; write = 1'b0;
  endtask

  task automatic rd(input int sel, input logic [2:0] a, input logic [7:0] e);
    logic [7:0] obs;
    exp_q.push_back(e);
    cs0 = (sel == 0); cs1 = (sel == 1);
    read = 1'b1; address = a;
    tick();
    cs0 = 1'b0; cs1 = 1'b0; read = 1'b0;
    obs = (sel == 1) ? rd1 : rd0;
    check($sformatf("read dut%0d a%0d", sel, a), 32'(obs), 32'(exp_q.pop_front()));
  endtask

  // One cycle at (vcount 480, hcount 0), then back into the active region.
  task automatic cp_pulse();
    vcount = 10'd480; hcount = 11'd0;
    exp_fc = exp_fc + 8'd1;
    tick();
    vcount = 10'd100; hcount = 11'd10;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    for (int i = 0; i < cycles; i++) tick();
    reset = 1'b0;
    exp_fc = 8'd0;
  endtask

  initial begin
    cs0 = 0; cs1 = 0; write = 0; read = 0; address = 0; writedata = 0;
    hcount = 11'd10; vcount = 10'd100; reset = 1'b0;
    tick();
    do_reset(2);

    // Reset state
    check("rst readdata", 32'(rd0), 32'h00);
    check("rst bg", {8'h0, bg_r0, bg_g0, bg_b0}, 32'h000080);
    check("rst h", {5'd0, hs0, 5'd0, he0}, 32'h0);
    check("rst v", {5'd0, vs0, 5'd0, ve0}, 32'h0);
    check("rst pending", 32'(cp0), 32'h0);
    check("rst fc", 32'(fc0), 32'h0);
    check("rst state", 32'(st0), 32'h0);
    rd(0, 3'd2, 8'h80);

    // Auto-commit instance: a dirty shadow arms itself
    wr(1, 3'd0, 8'hFF);
    tick();
    check("auto pending", 32'(cp1), 32'h1);
    check("auto bg_r before cp", 32'(bg_r1), 32'h00);
    cp_pulse();
    tick();
    check("auto bg_r", 32'(bg_r1), 32'hFF);
    rd(1, 3'd7, 8'h00);

    // Request-driven commit of h bounds
    wr(0, 3'd3, 8'd10);
    wr(0, 3'd4, 8'd20);
    wr(0, 3'd7, 8'h01);
    check("armed pending", 32'(cp0), 32'h1);
    rd(0, 3'd7, 8'hC0);
    for (int i = 0; i < 3; i++) tick();
    check("h_start before cp", 32'(hs0), 32'd0);
    cp_pulse();
    check("h_start at cp", 32'(hs0), 32'd0);
    check("pending falls", 32'(cp0), 32'h0);
    tick();
    check("h_start", 32'(hs0), 32'd50);
    check("h_end", 32'(he0), 32'd100);
    check("fc after cp", 32'(fc0), 32'(exp_fc));
    rd(0, 3'd7, 8'h00);

    // Swapped v bounds, and the 255*5 boundary with swapped h
    wr(0, 3'd5, 8'd40);
    wr(0, 3'd6, 8'd8);
    wr(0, 3'd3, 8'd255);
    wr(0, 3'd4, 8'd0);
    wr(0, 3'd7, 8'h01);
    cp_pulse();
    tick();
    check("v_start swapped", 32'(vs0), 32'd40);
    check("v_end swapped", 32'(ve0), 32'd200);
    check("h_start swapped", 32'(hs0), 32'd0);
    check("h_end max", 32'(he0), 32'd1275);
    rd(0, 3'd5, 8'd40);
    rd(0, 3'd6, 8'd8);
    rd(0, 3'd3, 8'd255);

    // Shadow write in the COMMIT cycle
    wr(0, 3'd7, 8'h01);
    cp_pulse();
    wr(0, 3'd1, 8'h33);
    check("bg_g keeps old", 32'(bg_g0), 32'h00);
    rd(0, 3'd7, 8'h40);
    wr(0, 3'd7, 8'h01);
    cp_pulse();
    tick();
    check("bg_g new", 32'(bg_g0), 32'h33);

    // Request in the COMMIT cycle re-arms
    wr(0, 3'd0, 8'h22);
    wr(0, 3'd7, 8'h01);
    cp_pulse();
    wr(0, 3'd7, 8'h01);
    check("rearm pending", 32'(cp0), 32'h1);
    check("rearm bg_r", 32'(bg_r0), 32'h22);
    wr(0, 3'd7, 8'hFE);
    check("bit0 clear no effect", 32'(st0), 32'h1);
    cp_pulse();
    tick();
    check("rearm done", 32'(cp0), 32'h0);

    // Request coinciding with cp while IDLE: commit waits a frame
    wr(0, 3'd2, 8'h44);
    vcount = 10'd480; hcount = 11'd0;
    exp_fc = exp_fc + 8'd1;
    wr(0, 3'd7, 8'h01);
    vcount = 10'd100; hcount = 11'd10;
    tick();
    check("same-cycle pending", 32'(cp0), 32'h1);
    check("same-cycle bg_b held", 32'(bg_b0), 32'h80);
    check("same-cycle fc", 32'(fc0), 32'(exp_fc));
    cp_pulse();
    tick();
    check("same-cycle bg_b", 32'(bg_b0), 32'h44);

    // Reset with a commit armed
    wr(0, 3'd0, 8'h11);
    wr(0, 3'd7, 8'h01);
    check("pre-reset pending", 32'(cp0), 32'h1);
    do_reset(1);
    check("reset pending", 32'(cp0), 32'h0);
    check("reset bg", {8'h0, bg_r0, bg_g0, bg_b0}, 32'h000080);
    check("reset h_end", 32'(he0), 32'd0);
    check("reset fc", 32'(fc0), 32'd0);
    cp_pulse();
    tick();
    check("no commit bg_r", 32'(bg_r0), 32'h00);
    check("no commit pending", 32'(cp0), 32'h0);
    check("fc from 0", 32'(fc0), 32'(exp_fc));

    // frame_count wrap 255 -> 0
    for (int i = 0; i < 254; i++) begin
      cp_pulse();
      tick();
    end
    check("fc 255", 32'(fc0), 32'(exp_fc));
    cp_pulse();
    check("fc wrap", 32'(fc0), 32'(exp_fc));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
